// File: rtl/tmds_rx_channel.sv
// Single-lane TMDS receive decoder. Finds the 10-bit symbol boundary by
// looking for runs of control tokens, asks the deserializer to bit-slip
// until it finds one, then decodes each symbol into video data or control.
module tmds_rx_channel #(
    parameter int LOCK_RUN      = 16,
    parameter int SEARCH_WINDOW = 4096,
    parameter int SLIP_WAIT     = 16
) (
    input  logic       clk_pixel,
    input  logic       sys_resetn,
    input  logic [9:0] tmds_sym,
    output logic       bitslip,
    output logic       locked,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    localparam int RUN_W  = $clog2(LOCK_RUN + 1);
    localparam int WIN_W  = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
    localparam int SLIP_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    localparam logic [RUN_W-1:0]  RUN_SAT   = RUN_W'(LOCK_RUN);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_RUN - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    state_t              state;
    logic [9:0]          s1;
    logic [RUN_W-1:0]    run_cnt;
    logic [RUN_W-1:0]    run_next;
    logic [WIN_W-1:0]    win_cnt;
    logic [SLIP_W-1:0]   slip_cnt;
    logic                is_ctrl;
    logic [1:0]          tok_ctrl;
    logic [7:0]          b;
    logic [7:0]          vid;
    logic                qualify;
    logic                win_last;

    // Stage 1: capture the raw deserializer word.
    always_ff @(posedge clk_pixel) begin
        // NOTE: registers use <= so every flop samples pre-edge values; a
        // blocking = here would let downstream blocks see the new value early.
        if (!sys_resetn) begin
            s1 <= '0;
        end else begin
            s1 <= tmds_sym;
        end
    end

    // Classify s1 as one of the four control tokens or as video.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and infers a latch.
        is_ctrl  = 1'b0;
        tok_ctrl = 2'b00;
        case (s1)
            10'h354: begin is_ctrl = 1'b1; tok_ctrl = 2'b00; end
            10'h0AB: begin is_ctrl = 1'b1; tok_ctrl = 2'b01; end
            10'h154: begin is_ctrl = 1'b1; tok_ctrl = 2'b10; end
            10'h2AB: begin is_ctrl = 1'b1; tok_ctrl = 2'b11; end
            default: begin is_ctrl = 1'b0; tok_ctrl = 2'b00; end
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        b      = s1[9] ? ~s1[7:0] : s1[7:0];
        vid    = '0;
        vid[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            vid[i] = s1[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        end
    end

    // Run/window bookkeeping shared by the state machine.
    always_comb begin
        if (!is_ctrl) begin
            run_next = '0;
        end else if (run_cnt == RUN_SAT) begin
            run_next = run_cnt;
        end else begin
            run_next = run_cnt + RUN_W'(1);
        end
        // The LOCK_RUN-th token is in s1 while the counter still reads
        // LOCK_RUN-1, so the run qualifies on that same edge.
        qualify  = is_ctrl && (run_cnt >= RUN_LAST) && (state != ST_SLIP_WAIT);
        win_last = (win_cnt == WIN_LAST);
    end

    // Alignment state machine: search, slip-and-settle, locked tracking.
    always_ff @(posedge clk_pixel) begin
        if (!sys_resetn) begin
            state    <= ST_SEARCH;
            run_cnt  <= '0;
            win_cnt  <= '0;
            slip_cnt <= '0;
            bitslip  <= 1'b0;
            locked   <= 1'b0;
        end else begin
            bitslip <= 1'b0;
            case (state)
                ST_SEARCH: begin
                    run_cnt <= run_next;
                    if (qualify) begin
                        state   <= ST_LOCKED;
                        locked  <= 1'b1;
                        win_cnt <= '0;
                    end else if (win_last) begin
                        state    <= ST_SLIP_WAIT;
                        bitslip  <= 1'b1;
                        win_cnt  <= '0;
                        slip_cnt <= '0;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end
                ST_LOCKED: begin
                    run_cnt <= run_next;
                    if (qualify) begin
                        win_cnt <= '0;
                    end else if (win_last) begin
                        state    <= ST_SLIP_WAIT;
                        locked   <= 1'b0;
                        bitslip  <= 1'b1;
                        win_cnt  <= '0;
                        slip_cnt <= '0;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end
                ST_SLIP_WAIT: begin
                    // Symbols are meaningless while the deserializer settles.
                    run_cnt <= '0;
                    win_cnt <= '0;
                    if (slip_cnt == SLIP_LAST) begin
                        state    <= ST_SEARCH;
                        slip_cnt <= '0;
                    end else begin
                        slip_cnt <= slip_cnt + SLIP_W'(1);
                    end
                end
                default: begin
                    state   <= ST_SEARCH;
                    run_cnt <= '0;
                    win_cnt <= '0;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 2: registered outputs, gated off while not locked.
    always_ff @(posedge clk_pixel) begin
        if (!sys_resetn || !locked) begin
            de   <= 1'b0;
            ctrl <= 2'b00;
            data <= 8'h00;
        end else if (is_ctrl) begin
            de   <= 1'b0;
            ctrl <= tok_ctrl;
            data <= 8'h00;
        end else begin
            de   <= 1'b1;
            data <= vid;
        end
    end

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Self-checking bench for tmds_rx_channel. A timestamp-based reference model
// predicts lock, slip and decoded output from the symbol history; video is
// produced by a TMDS encoder so the expected byte is simply the source byte.
module tb_tmds_rx_channel;

    localparam int LOCK_RUN      = 16;
    localparam int SEARCH_WINDOW = 4096;
    localparam int SLIP_WAIT     = 16;

    logic       clk_pixel  = 1'b0;
    logic       sys_resetn = 1'b0;
    logic [9:0] tmds_sym   = '0;
    logic       bitslip;
    logic       locked;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;

    int n_cmp = 0;
    int n_bad = 0;

    tmds_rx_channel #(
        .LOCK_RUN(LOCK_RUN),
        .SEARCH_WINDOW(SEARCH_WINDOW),
        .SLIP_WAIT(SLIP_WAIT)
    ) dut (
        .clk_pixel(clk_pixel),
        .sys_resetn(sys_resetn),
        .tmds_sym(tmds_sym),
        .bitslip(bitslip),
        .locked(locked),
        .de(de),
        .ctrl(ctrl),
        .data(data)
    );

    always #5 clk_pixel = ~clk_pixel;

    // One sample of the symbol stream as the model remembers it.
    typedef struct {
        int         stamp;
        bit         tok;
        bit         known;
        logic [1:0] c;
        logic [7:0] b;
    } rec_t;

    logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    rec_t       hist[$];
    int         cyc        = 0;
    int         slip_from  = -100000;
    int         win_start  = 0;
    int         valid_from = 0;
    logic       m_locked   = 1'b0;
    logic       m_bitslip  = 1'b0;
    logic       m_de       = 1'b0;
    logic [1:0] m_ctrl     = 2'b00;
    logic [7:0] m_data     = 8'h00;
    bit         m_known    = 1'b1;

    function automatic bit is_token(input logic [9:0] s, output logic [1:0] c);
        c = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (s == toks[i]) begin
                c = 2'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Transmit-side TMDS video encoding (inversion chosen by caller).
    function automatic logic [9:0] enc_video(input logic [7:0] d, input logic inv);
        logic [7:0] q;
        int         n1;
        logic       use_xnor;
        n1       = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        return {inv, ~use_xnor, inv ? ~q : q};
    endfunction

    function automatic string obs_str();
        return $sformatf("got bs=%b lk=%b de=%b ctrl=%b data=%h / exp bs=%b lk=%b de=%b ctrl=%b data=%h",
                         bitslip, locked, de, ctrl, data,
                         m_bitslip, m_locked, m_de, m_ctrl, m_data);
    endfunction

    // Drive one symbol, advance one edge, update the model, settle 1 time unit.
    task automatic step(input logic [9:0] sym, input bit known, input logic [7:0] byt);
        rec_t       r;
        bit         qual;
        bit         in_slip;
        bit         expire;
        logic [1:0] c;
        int         e;
        tmds_sym = sym;
        @(posedge clk_pixel);
        cyc++;
        e = cyc;
        if (!sys_resetn) begin
            m_locked   = 1'b0;
            m_bitslip  = 1'b0;
            m_de       = 1'b0;
            m_ctrl     = 2'b00;
            m_data     = 8'h00;
            m_known    = 1'b1;
            hist.delete();
            valid_from = e + 1;
            win_start  = e;
            slip_from  = -100000;
        end else begin
            in_slip = (e > slip_from) && (e <= slip_from + SLIP_WAIT);
            // Qualifying: the last LOCK_RUN samples are all tokens, all taken
            // since the last reset or settle period.
            qual = 1'b0;
            if (!in_slip && hist.size() >= LOCK_RUN &&
                hist[hist.size() - LOCK_RUN].stamp >= valid_from) begin
                qual = 1'b1;
                for (int i = hist.size() - LOCK_RUN; i < hist.size(); i++) begin
                    if (!hist[i].tok) qual = 1'b0;
                end
            end
            expire = !in_slip && !qual && (e - win_start == SEARCH_WINDOW);
            if (m_locked && hist.size() > 0) begin
                r = hist[$];
                if (r.tok) begin
                    m_de    = 1'b0;
                    m_ctrl  = r.c;
                    m_data  = 8'h00;
                    m_known = 1'b1;
                end else begin
                    m_de    = 1'b1;
                    m_data  = r.b;
                    m_known = r.known;
                end
            end else begin
                m_de    = 1'b0;
                m_ctrl  = 2'b00;
                m_data  = 8'h00;
                m_known = 1'b1;
            end
            m_bitslip = expire;
            if (qual) begin
                m_locked  = 1'b1;
                win_start = e;
            end
            if (expire) begin
                m_locked  = 1'b0;
                slip_from = e;
            end
            if (in_slip && e == slip_from + SLIP_WAIT) begin
                win_start  = e;
                valid_from = e;
            end
            r.stamp = e;
            r.tok   = is_token(sym, c);
            r.c     = c;
            r.known = known;
            r.b     = byt;
            hist.push_back(r);
            if (hist.size() > LOCK_RUN) void'(hist.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        sys_resetn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(10'($urandom_range(0, 1023)), 1'b1, 8'h00);
            n_cmp++;
            if ({bitslip, locked, de, ctrl, data} !== 13'h0) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got=%b required=0", cyc,
                         {bitslip, locked, de, ctrl, data});
            end
        end
        // First token sampled at edge k (i=0); locked must rise after k+LOCK_RUN.
        sys_resetn = 1'b1;
        for (int i = 0; i <= LOCK_RUN + 2; i++) begin
            step(10'h354, 1'b1, 8'h00);
            n_cmp++;
            if (locked !== (i >= LOCK_RUN) || bitslip !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_lock_timing edge=k+%0d locked=%b bitslip=%b required locked=%b bitslip=0",
                         i, locked, bitslip, (i >= LOCK_RUN));
            end
            n_cmp++;
            if ({bitslip, locked, de, ctrl} !== {m_bitslip, m_locked, m_de, m_ctrl} ||
                (m_known && data !== m_data)) begin
                n_bad++;
                $display("FAIL reset_model cyc=%0d %s", cyc, obs_str());
            end
        end
        n_cmp++;
        if (de !== 1'b0 || ctrl !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ctrl00 de=%b ctrl=%b required de=0 ctrl=00", de, ctrl);
        end
    endtask

    task automatic test_video();
        logic [9:0] seq [6];
        logic [7:0] byt;
        seq[0] = enc_video(8'hA5, 1'b0);
        seq[1] = enc_video(8'h00, 1'b1);
        seq[2] = 10'h2AB;
        seq[3] = 10'h354;
        seq[4] = 10'h354;
        seq[5] = 10'h354;
        for (int i = 0; i < 6; i++) begin
            step(seq[i], 1'b1, (i == 0) ? 8'hA5 : 8'h00);
            // Symbol driven before edge j shows on the outputs after edge j+1.
            if (i == 1) begin
                n_cmp++;
                if (de !== 1'b1 || data !== 8'hA5) begin
                    n_bad++;
                    $display("FAIL video_A5 de=%b data=%h required de=1 data=a5", de, data);
                end
            end
            if (i == 2) begin
                n_cmp++;
                if (de !== 1'b1 || data !== 8'h00) begin
                    n_bad++;
                    $display("FAIL video_00 de=%b data=%h required de=1 data=00", de, data);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (de !== 1'b0 || ctrl !== 2'b11 || data !== 8'h00) begin
                    n_bad++;
                    $display("FAIL video_tok2AB de=%b ctrl=%b data=%h required de=0 ctrl=11 data=00",
                             de, ctrl, data);
                end
            end
        end
        // Random video bursts with isolated tokens, then a run to stay locked.
        for (int i = 0; i < 300; i++) begin
            if (i >= 280) begin
                step(10'h354, 1'b1, 8'h00);
            end else if ($urandom_range(0, 9) == 0) begin
                step(toks[$urandom_range(0, 3)], 1'b1, 8'h00);
            end else begin
                byt = 8'($urandom);
                step(enc_video(byt, 1'($urandom)), 1'b1, byt);
            end
            n_cmp++;
            if ({bitslip, locked, de, ctrl} !== {m_bitslip, m_locked, m_de, m_ctrl} ||
                (m_known && data !== m_data)) begin
                n_bad++;
                $display("FAIL video_model cyc=%0d %s", cyc, obs_str());
            end
        end
    endtask

    task automatic test_loss_of_lock();
        logic [7:0] byt;
        for (int i = 0; i < 20; i++) step(10'h354, 1'b1, 8'h00);
        // Last qualifying edge is the first video edge; expiry 4096 edges later.
        for (int v = 0; v <= SEARCH_WINDOW + 4; v++) begin
            byt = 8'($urandom);
            step(enc_video(byt, 1'($urandom)), 1'b1, byt);
            n_cmp++;
            if ({bitslip, locked, de, ctrl} !== {m_bitslip, m_locked, m_de, m_ctrl} ||
                (m_known && data !== m_data)) begin
                n_bad++;
                $display("FAIL loss_model cyc=%0d %s", cyc, obs_str());
            end
            if (v == SEARCH_WINDOW - 1) begin
                n_cmp++;
                if (bitslip !== 1'b0 || locked !== 1'b1) begin
                    n_bad++;
                    $display("FAIL loss_before bitslip=%b locked=%b required bitslip=0 locked=1",
                             bitslip, locked);
                end
            end
            if (v == SEARCH_WINDOW) begin
                n_cmp++;
                if (bitslip !== 1'b1 || locked !== 1'b0 || de !== 1'b1) begin
                    n_bad++;
                    $display("FAIL loss_edge bitslip=%b locked=%b de=%b required bitslip=1 locked=0 de=1",
                             bitslip, locked, de);
                end
            end
            if (v == SEARCH_WINDOW + 1) begin
                n_cmp++;
                if (bitslip !== 1'b0 || de !== 1'b0) begin
                    n_bad++;
                    $display("FAIL loss_gated bitslip=%b de=%b required bitslip=0 de=0", bitslip, de);
                end
            end
        end
    endtask

    task automatic test_reset_mid_slip();
        // Entered SLIP_WAIT a few edges ago; reset before it can finish.
        sys_resetn = 1'b0;
        step(10'h354, 1'b1, 8'h00);
        n_cmp++;
        if ({bitslip, locked, de, ctrl, data} !== 13'h0) begin
            n_bad++;
            $display("FAIL midslip_reset got=%b required=0", {bitslip, locked, de, ctrl, data});
        end
        sys_resetn = 1'b1;
        for (int i = 0; i <= LOCK_RUN + 2; i++) begin
            step(10'h354, 1'b1, 8'h00);
            n_cmp++;
            if (locked !== (i >= LOCK_RUN) || bitslip !== 1'b0) begin
                n_bad++;
                $display("FAIL midslip_relock edge=k+%0d locked=%b bitslip=%b required locked=%b bitslip=0",
                         i, locked, bitslip, (i >= LOCK_RUN));
            end
            n_cmp++;
            if ({bitslip, locked, de, ctrl} !== {m_bitslip, m_locked, m_de, m_ctrl} ||
                (m_known && data !== m_data)) begin
                n_bad++;
                $display("FAIL midslip_model cyc=%0d %s", cyc, obs_str());
            end
        end
    endtask

    task automatic test_tie();
        logic [7:0] byt;
        sys_resetn = 1'b0;
        step(10'h354, 1'b1, 8'h00);
        step(10'h354, 1'b1, 8'h00);
        sys_resetn = 1'b1;
        // Step s lands on edge R+s; the run completes on edge R+SEARCH_WINDOW.
        for (int s = 1; s <= SEARCH_WINDOW + 1; s++) begin
            if (s < SEARCH_WINDOW - LOCK_RUN) begin
                byt = 8'($urandom);
                step(enc_video(byt, 1'($urandom)), 1'b1, byt);
            end else begin
                step(10'h354, 1'b1, 8'h00);
            end
            n_cmp++;
            if ({bitslip, locked, de, ctrl} !== {m_bitslip, m_locked, m_de, m_ctrl} ||
                (m_known && data !== m_data)) begin
                n_bad++;
                $display("FAIL tie_model cyc=%0d %s", cyc, obs_str());
            end
            if (s == SEARCH_WINDOW - 1 || s == SEARCH_WINDOW) begin
                n_cmp++;
                if (bitslip !== 1'b0 || locked !== (s == SEARCH_WINDOW)) begin
                    n_bad++;
                    $display("FAIL tie_edge s=%0d bitslip=%b locked=%b required bitslip=0 locked=%b",
                             s, bitslip, locked, (s == SEARCH_WINDOW));
                end
            end
        end
    endtask

    task automatic test_slip_align();
        int         mis    = 3;
        int         pos    = 0;
        int         lock_at = -1;
        int         pulses[$];
        logic [9:0] prev_w = 10'h354;
        logic [9:0] w;
        logic [7:0] prev_b = 8'h00;
        logic [7:0] byt;
        logic [19:0] cat;
        sys_resetn = 1'b0;
        step(10'h354, 1'b1, 8'h00);
        step(10'h354, 1'b1, 8'h00);
        sys_resetn = 1'b1;
        for (int n = 0; n < 20000 && (lock_at < 0 || cyc < lock_at + 200); n++) begin
            // 720p-like line: 1280 active pixels, 370 blanking tokens.
            if (pos < 1280) begin
                byt = 8'($urandom);
                w   = enc_video(byt, 1'($urandom));
            end else begin
                byt = 8'h00;
                w   = 10'h354;
            end
            pos = (pos == 1649) ? 0 : pos + 1;
            // Deserializer model: word boundary sits mis bits into the stream.
            cat = {w, prev_w} >> mis;
            step(cat[9:0], (mis == 0), prev_b);
            prev_w = w;
            prev_b = byt;
            n_cmp++;
            if ({bitslip, locked, de, ctrl} !== {m_bitslip, m_locked, m_de, m_ctrl} ||
                (m_known && data !== m_data)) begin
                n_bad++;
                $display("FAIL slip_model cyc=%0d mis=%0d %s", cyc, mis, obs_str());
            end
            if (bitslip === 1'b1) begin
                pulses.push_back(cyc);
                mis = (mis + 9) % 10;
            end
            if (locked === 1'b1 && lock_at < 0) lock_at = cyc;
        end
        n_cmp++;
        if (pulses.size() != 3) begin
            n_bad++;
            $display("FAIL slip_count pulses=%0d required=3", pulses.size());
        end
        for (int i = 1; i < pulses.size(); i++) begin
            n_cmp++;
            if (pulses[i] - pulses[i-1] != SLIP_WAIT + SEARCH_WINDOW) begin
                n_bad++;
                $display("FAIL slip_spacing gap=%0d required=%0d", pulses[i] - pulses[i-1],
                         SLIP_WAIT + SEARCH_WINDOW);
            end
        end
        n_cmp++;
        if (lock_at < 0 || mis != 0) begin
            n_bad++;
            $display("FAIL slip_lock lock_at=%0d mis=%0d required lock with mis=0", lock_at, mis);
        end
    endtask

    initial begin
        test_reset();
        test_video();
        test_loss_of_lock();
        test_reset_mid_slip();
        test_tie();
        test_slip_align();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
